// File: rtl/rr_priority_encoder_pkg.sv
// Shared sizing and FSM encoding for the round-robin priority encoder.
package rr_priority_encoder_pkg;

    localparam int N = 32;
    localparam int W = 5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_priority_encoder_search.sv
// Combinational round-robin search: first set bit of req starting at ptr and wrapping.
module rr_search
    import rr_priority_encoder_pkg::*;
(
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         found
);

    logic [N-1:0] rot;
    logic [W-1:0] rot_idx;

    // rot[k] is the request k positions after ptr; the 5-bit add wraps mod 32.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            logic [W-1:0] src;
            assign src     = W'(gi) + ptr;
            assign rot[gi] = req[src];
        end
    endgenerate

    always_comb begin
        rot_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                rot_idx = W'(i);
            end
        end
    end

    assign found = |req;
    assign idx   = rot_idx + ptr;

endmodule

// File: rtl/rr_priority_encoder.sv
// Sequential 32-to-5 encoder: captures request strobes into a pending set and
// hands out one index at a time in round-robin order, holding each until acked.
module rr_priority_encoder
    import rr_priority_encoder_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] iReq,
    input  logic         iEna,
    input  logic         iAck,
    output logic [W-1:0] oData,
    output logic         oValid,
    output logic [N-1:0] oPending
);

    state_t       state_reg, state_next;
    logic [N-1:0] pending_reg, pending_next;
    logic [W-1:0] ptr_reg, ptr_next;
    logic [W-1:0] data_reg, data_next;
    logic [N-1:0] clr_mask;
    logic [W-1:0] search_idx;
    logic         search_found;
    logic         ack_fire;

    assign ack_fire = (state_reg == ST_GRANT) && iAck;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_clr
            assign clr_mask[gi] = ack_fire && (data_reg == W'(gi));
        end
    endgenerate

    // Set is applied after clear so a same-cycle re-request survives its own ack.
    assign pending_next = (pending_reg & ~clr_mask) | (iEna ? iReq : '0);

    rr_search u_search (
        .req   (pending_reg),
        .ptr   (ptr_reg),
        .idx   (search_idx),
        .found (search_found)
    );

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        data_next  = data_reg;
        case (state_reg)
            ST_IDLE: begin
                if (search_found) begin
                    data_next  = search_idx;
                    state_next = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (iAck) begin
                    ptr_next   = data_reg + W'(1);
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            pending_reg <= '0;
            ptr_reg     <= '0;
            data_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            ptr_reg     <= ptr_next;
            data_reg    <= data_next;
        end
    end

    assign oData    = data_reg;
    assign oValid   = (state_reg == ST_GRANT);
    assign oPending = pending_reg;

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Self-checking bench for rr_priority_encoder: directed scenarios plus random traffic against a set-based model.
module tb_rr_priority_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] iReq = '0;
    logic        iEna = 1'b0;
    logic        iAck = 1'b0;
    logic [4:0]  oData;
    logic        oValid;
    logic [31:0] oPending;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [31:0] m_pending = '0;
    int          m_ptr     = 0;
    int          m_data    = 0;
    logic        m_valid   = 1'b0;

    rr_priority_encoder dut (
        .clk      (clk),
        .rst      (rst),
        .iReq     (iReq),
        .iEna     (iEna),
        .iAck     (iAck),
        .oData    (oData),
        .oValid   (oValid),
        .oPending (oPending)
    );

    always #5 clk = ~clk;

    function automatic int rr_pick(input logic [31:0] p, input int start);
        for (int k = 0; k < 32; k++) begin
            if (p[(start + k) % 32]) return (start + k) % 32;
        end
        return -1;
    endfunction

    // One clock: drive inputs, advance the model across the edge, settle.
    task automatic step(input logic r, input logic [31:0] req, input logic ena, input logic ack);
        logic [31:0] np;
        int          pick;
        @(negedge clk);
        rst = r; iReq = req; iEna = ena; iAck = ack;
        @(posedge clk);
        if (r) begin
            m_pending = '0; m_ptr = 0; m_data = 0; m_valid = 1'b0;
        end else begin
            np = m_pending;
            if (m_valid && ack) np[m_data] = 1'b0;
            if (ena) np = np | req;
            if (!m_valid) begin
                pick = rr_pick(m_pending, m_ptr);
                if (pick >= 0) begin
                    m_data  = pick;
                    m_valid = 1'b1;
                end
            end else if (ack) begin
                m_valid = 1'b0;
                m_ptr   = (m_data + 1) % 32;
            end
            m_pending = np;
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, '0, 1'b0, 1'b0);
        n_cmp++;
        if ({oValid, oData, oPending} !== {1'b0, 5'd0, 32'h0}) begin
            n_bad++;
            $display("FAIL reset: got v=%0b d=%0d p=%h want v=0 d=0 p=00000000", oValid, oData, oPending);
        end
    endtask

    task automatic test_single();
        step(1'b1, '0, 1'b1, 1'b0);
        step(1'b0, 32'h1, 1'b1, 1'b0);
        n_cmp++;
        if ({oValid, oPending} !== {1'b0, 32'h1}) begin
            n_bad++;
            $display("FAIL single_capture: got v=%0b p=%h want v=0 p=00000001", oValid, oPending);
        end
        step(1'b0, '0, 1'b1, 1'b0);
        n_cmp++;
        if ({oValid, oData} !== {1'b1, 5'd0}) begin
            n_bad++;
            $display("FAIL single_grant: got v=%0b d=%0d want v=1 d=0", oValid, oData);
        end
        step(1'b0, '0, 1'b1, 1'b1);
        n_cmp++;
        if ({oValid, oPending} !== {1'b0, 32'h0}) begin
            n_bad++;
            $display("FAIL single_ack: got v=%0b p=%h want v=0 p=00000000", oValid, oPending);
        end
        // ptr is now 1: with bits 0 and 1 pending, 1 must win
        step(1'b0, 32'h3, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        n_cmp++;
        if ({oValid, oData} !== {1'b1, 5'd1}) begin
            n_bad++;
            $display("FAIL single_ptr: got v=%0b d=%0d want v=1 d=1", oValid, oData);
        end
    endtask

    task automatic test_wrap();
        step(1'b1, '0, 1'b1, 1'b0);
        step(1'b0, 32'h8000_0001, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        n_cmp++;
        if ({oValid, oData} !== {1'b1, 5'd0}) begin
            n_bad++;
            $display("FAIL wrap_first: got v=%0b d=%0d want v=1 d=0", oValid, oData);
        end
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        n_cmp++;
        if ({oValid, oData} !== {1'b1, 5'd31}) begin
            n_bad++;
            $display("FAIL wrap_31: got v=%0b d=%0d want v=1 d=31", oValid, oData);
        end
        step(1'b0, '0, 1'b1, 1'b1);
        // ptr wrapped to 0: of {5,31}, 5 comes first
        step(1'b0, 32'h8000_0020, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        n_cmp++;
        if ({oValid, oData} !== {1'b1, 5'd5}) begin
            n_bad++;
            $display("FAIL wrap_ptr0: got v=%0b d=%0d want v=1 d=5", oValid, oData);
        end
    endtask

    task automatic test_rotate();
        step(1'b1, '0, 1'b1, 1'b0);
        step(1'b0, 32'h10, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, 32'h204, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        n_cmp++;
        if ({oValid, oData} !== {1'b1, 5'd9}) begin
            n_bad++;
            $display("FAIL rotate_9: got v=%0b d=%0d want v=1 d=9", oValid, oData);
        end
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        n_cmp++;
        if ({oValid, oData} !== {1'b1, 5'd2}) begin
            n_bad++;
            $display("FAIL rotate_2: got v=%0b d=%0d want v=1 d=2", oValid, oData);
        end
    endtask

    task automatic test_hold();
        logic [31:0] req;
        step(1'b1, '0, 1'b1, 1'b0);
        step(1'b0, 32'h1000, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        for (int c = 0; c < 10; c++) begin
            req = (c == 2) ? 32'h80 : (c == 5) ? 32'h0010_0000 : 32'h0;
            step(1'b0, req, 1'b1, 1'b0);
            n_cmp++;
            if ({oValid, oData} !== {1'b1, 5'd12}) begin
                n_bad++;
                $display("FAIL hold_stable c=%0d: got v=%0b d=%0d want v=1 d=12", c, oValid, oData);
            end
        end
        n_cmp++;
        if (oPending !== 32'h0010_1080) begin
            n_bad++;
            $display("FAIL hold_accum: got p=%h want p=00101080", oPending);
        end
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        n_cmp++;
        if ({oValid, oData} !== {1'b1, 5'd20}) begin
            n_bad++;
            $display("FAIL hold_serve20: got v=%0b d=%0d want v=1 d=20", oValid, oData);
        end
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        n_cmp++;
        if ({oValid, oData} !== {1'b1, 5'd7}) begin
            n_bad++;
            $display("FAIL hold_serve7: got v=%0b d=%0d want v=1 d=7", oValid, oData);
        end
    endtask

    task automatic test_disable();
        step(1'b1, '0, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
            n_cmp++;
            if ({oValid, oPending} !== {1'b0, 32'h0}) begin
                n_bad++;
                $display("FAIL disable c=%0d: got v=%0b p=%h want v=0 p=00000000", c, oValid, oPending);
            end
        end
    endtask

    task automatic test_set_wins_and_reset();
        step(1'b1, '0, 1'b1, 1'b0);
        step(1'b0, 32'h8, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, 32'h8, 1'b1, 1'b1);
        n_cmp++;
        if ({oValid, oPending} !== {1'b0, 32'h8}) begin
            n_bad++;
            $display("FAIL setwins_keep: got v=%0b p=%h want v=0 p=00000008", oValid, oPending);
        end
        step(1'b0, '0, 1'b1, 1'b0);
        n_cmp++;
        if ({oValid, oData} !== {1'b1, 5'd3}) begin
            n_bad++;
            $display("FAIL setwins_regrant: got v=%0b d=%0d want v=1 d=3", oValid, oData);
        end
        step(1'b1, 32'hFF, 1'b1, 1'b0);
        n_cmp++;
        if ({oValid, oData, oPending} !== {1'b0, 5'd0, 32'h0}) begin
            n_bad++;
            $display("FAIL reset_midgrant: got v=%0b d=%0d p=%h want v=0 d=0 p=00000000", oValid, oData, oPending);
        end
    endtask

    task automatic test_all32();
        step(1'b1, '0, 1'b1, 1'b0);
        step(1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        for (int k = 0; k < 32; k++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            n_cmp++;
            if ({oValid, oData} !== {1'b1, 5'(k)}) begin
                n_bad++;
                $display("FAIL all32 k=%0d: got v=%0b d=%0d want v=1 d=%0d", k, oValid, oData, k);
            end
            step(1'b0, '0, 1'b1, 1'b1);
        end
        n_cmp++;
        if ({oValid, oPending} !== {1'b0, 32'h0}) begin
            n_bad++;
            $display("FAIL all32_drained: got v=%0b p=%h want v=0 p=00000000", oValid, oPending);
        end
    endtask

    task automatic test_random();
        logic        r;
        logic [31:0] req;
        step(1'b1, '0, 1'b1, 1'b0);
        for (int c = 0; c < 600; c++) begin
            r   = ($urandom_range(0, 99) == 0);
            req = $urandom & $urandom & $urandom;
            step(r, req, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1);
            n_cmp++;
            if ({oValid, oPending} !== {m_valid, m_pending} || (m_valid && oData !== 5'(m_data))) begin
                n_bad++;
                $display("FAIL random c=%0d: got v=%0b d=%0d p=%h want v=%0b d=%0d p=%h",
                         c, oValid, oData, oPending, m_valid, m_data, m_pending);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_rotate();
        test_hold();
        test_disable();
        test_set_wins_and_reset();
        test_all32();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
